// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: device command/response bytes, the init sequencer
// state encoding and the command-list lookup used by the sequencer.
package ps2_pkg;

    // Host-to-device commands
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Device-to-host responses
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERR      = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] DEV_ID_MOUSE = 8'h00;

    // Positions in the power-up command list
    localparam int         CMD_COUNT  = 4;
    localparam logic [1:0] IDX_RESET  = 2'd0;
    localparam logic [1:0] IDX_RATE   = 2'd1;
    localparam logic [1:0] IDX_ARG    = 2'd2;
    localparam logic [1:0] IDX_ENABLE = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_RESTART,
        ST_STREAM,
        ST_ERROR
    } init_state_t;

    // Byte sent at a given position of the power-up list; the rate argument
    // is the only entry that depends on configuration.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [7:0] rate);
        logic [7:0] result;
        case (idx)
            IDX_RESET: result = CMD_RESET;
            IDX_RATE:  result = CMD_SET_RATE;
            IDX_ARG:   result = rate;
            default:   result = CMD_ENABLE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating cycle counter with a synchronous clear; expired is high whenever
// the count has reached the currently selected limit.
module ps2_timeout_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    // Count up from zero after each clear, holding at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_reg != {WIDTH{1'b1}}) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg >= limit);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer: sends FF, F3, rate, F4, validates every
// device reply, handles resend requests, timeouts and bounded restarts, and
// finally hands the link to the packet parser through stream_en.
module ps2_mouse_init_ctrl
    import ps2_pkg::*;
#(
    parameter logic [15:0] RESP_TIMEOUT = 16'd50000,
    parameter logic [23:0] BAT_TIMEOUT  = 24'd10000000,
    parameter int          MAX_RETRY    = 3,
    parameter logic [7:0]  SAMPLE_RATE  = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_nak,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       stream_en,
    output logic       init_done,
    output logic       error,
    output logic [1:0] retry_cnt
);

    localparam logic [1:0] RETRY_LIMIT  = 2'(MAX_RETRY);
    // Three resends are honoured; the fourth FE in a row forces a restart
    localparam logic [1:0] RESEND_LIMIT = 2'd3;

    init_state_t state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [1:0]  retry_reg, retry_next;
    logic [1:0]  resend_reg, resend_next;
    logic        tx_req_reg, tx_req_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic        stream_en_reg, stream_en_next;
    logic        init_done_reg, init_done_next;
    logic        error_reg, error_next;

    logic        timer_clear;
    logic        timer_expired;
    logic [23:0] timer_limit;

    // Command list, one entry per sequence position
    logic [7:0] cmd_table [CMD_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < CMD_COUNT; gi++) begin : g_cmd_table
            assign cmd_table[gi] = cmd_byte(2'(gi), SAMPLE_RATE);
        end
    endgenerate

    // The timer restarts on every state change; the ack wait uses the short
    // limit, the BAT and ID waits use the long one.
    assign timer_clear = (state_next != state_reg);
    assign timer_limit = (state_reg == ST_WAIT_ACK) ? {8'h00, RESP_TIMEOUT} : BAT_TIMEOUT;

    ps2_timeout_timer #(
        .WIDTH (24)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    // Register state and all outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 2'd0;
            retry_reg     <= 2'd0;
            resend_reg    <= 2'd0;
            tx_req_reg    <= 1'b0;
            tx_byte_reg   <= 8'h00;
            stream_en_reg <= 1'b0;
            init_done_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            retry_reg     <= retry_next;
            resend_reg    <= resend_next;
            tx_req_reg    <= tx_req_next;
            tx_byte_reg   <= tx_byte_next;
            stream_en_reg <= stream_en_next;
            init_done_reg <= init_done_next;
            error_reg     <= error_next;
        end
    end

    // Next-state logic and next values of the registered outputs
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        retry_next     = retry_reg;
        resend_next    = resend_reg;
        init_done_next = init_done_reg;
        tx_req_next    = 1'b0;
        tx_byte_next   = tx_byte_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_SEND;
                    idx_next    = IDX_RESET;
                    retry_next  = 2'd0;
                    resend_next = 2'd0;
                end
            end

            ST_SEND: begin
                tx_req_next  = 1'b1;
                tx_byte_next = cmd_table[idx_reg];
                state_next   = ST_WAIT_TX;
            end

            // Any byte arriving while the transmitter is busy is dropped
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_next = tx_nak ? ST_RESTART : ST_WAIT_ACK;
                end
            end

            // A received byte takes priority over a timeout in the same cycle
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    case (rx_byte)
                        RSP_ACK: begin
                            resend_next = 2'd0;
                            if (idx_reg == IDX_RESET) begin
                                state_next = ST_WAIT_BAT;
                            end else if (idx_reg == IDX_ENABLE) begin
                                state_next = ST_STREAM;
                            end else begin
                                idx_next   = idx_reg + 2'd1;
                                state_next = ST_SEND;
                            end
                        end
                        RSP_RESEND: begin
                            if (resend_reg == RESEND_LIMIT) begin
                                state_next = ST_RESTART;
                            end else begin
                                resend_next = resend_reg + 2'd1;
                                state_next  = ST_SEND;
                            end
                        end
                        default: state_next = ST_RESTART;
                    endcase
                end else if (timer_expired) begin
                    state_next = ST_RESTART;
                end
            end

            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    state_next = (rx_byte == RSP_BAT_OK) ? ST_WAIT_ID : ST_RESTART;
                end else if (timer_expired) begin
                    state_next = ST_RESTART;
                end
            end

            ST_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_byte == DEV_ID_MOUSE) begin
                        idx_next    = IDX_RATE;
                        resend_next = 2'd0;
                        state_next  = ST_SEND;
                    end else begin
                        state_next = ST_RESTART;
                    end
                end else if (timer_expired) begin
                    state_next = ST_RESTART;
                end
            end

            ST_RESTART: begin
                resend_next = 2'd0;
                if (retry_reg == RETRY_LIMIT) begin
                    state_next = ST_ERROR;
                end else begin
                    retry_next = retry_reg + 2'd1;
                    idx_next   = IDX_RESET;
                    state_next = ST_SEND;
                end
            end

            // STREAM and ERROR are only left by a new start (or reset)
            ST_STREAM, ST_ERROR: begin
                if (start) begin
                    state_next     = ST_SEND;
                    idx_next       = IDX_RESET;
                    retry_next     = 2'd0;
                    resend_next    = 2'd0;
                    init_done_next = 1'b0;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        if (state_next == ST_STREAM && state_reg != ST_STREAM) begin
            init_done_next = 1'b1;
        end

        stream_en_next = (state_next == ST_STREAM);
        error_next     = (state_next == ST_ERROR);
    end

    assign tx_req    = tx_req_reg;
    assign tx_byte   = tx_byte_reg;
    assign stream_en = stream_en_reg;
    assign init_done = init_done_reg;
    assign error     = error_reg;
    assign retry_cnt = retry_reg;

endmodule
